// File: rtl/czono_plus_ctrl.sv
// Sequencer for the constrained-zonotope Minkowski sum OUT = Z (+) W.
// Checks operand dims, streams center indices through the shared adder, writes sums back.
module czono_plus_ctrl #(
  parameter int NMAX       = 512,
  parameter int NGMAX      = 512,
  parameter int NCMAX      = 512,
  parameter int DATA_WIDTH = 32,
  parameter int ADD_LAT    = 1,
  localparam int NW = $clog2(NMAX + 1),
  localparam int IW = $clog2(NMAX),
  localparam int GW = $clog2(NGMAX + 1),
  localparam int CW = $clog2(NCMAX + 1)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [NW-1:0]         z_n_i,
  input  logic [NW-1:0]         w_n_i,
  input  logic [GW-1:0]         z_ng_i,
  input  logic [GW-1:0]         w_ng_i,
  input  logic [CW-1:0]         z_nc_i,
  input  logic [CW-1:0]         w_nc_i,
  output logic                  rd_vld_o,
  output logic [IW-1:0]         rd_idx_o,
  input  logic [DATA_WIDTH-1:0] sum_i,
  output logic                  wr_en_o,
  output logic [IW-1:0]         wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic [NW-1:0]         out_n_o,
  output logic [GW:0]           out_ng_o,
  output logic [CW:0]           out_nc_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_DRAIN, S_DONE, S_ERR} state_e;

  localparam logic [GW:0] NG_LIM = NGMAX[GW:0];
  localparam logic [CW:0] NC_LIM = NCMAX[CW:0];

  state_e          state_q, state_d;
  logic [NW-1:0]   z_n_q, z_n_d, w_n_q, w_n_d;
  logic [GW-1:0]   z_ng_q, z_ng_d, w_ng_q, w_ng_d;
  logic [CW-1:0]   z_nc_q, z_nc_d, w_nc_q, w_nc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NW-1:0]   out_n_q, out_n_d;
  logic [GW:0]     out_ng_q, out_ng_d, ng_sum;
  logic [CW:0]     out_nc_q, out_nc_d, nc_sum;
  logic [1:0]      err_code_q, err_code_d;
  logic            pipe_empty;

  assign ng_sum = {1'b0, z_ng_q} + {1'b0, w_ng_q};
  assign nc_sum = {1'b0, z_nc_q} + {1'b0, w_nc_q};

  always_comb begin
    state_d    = state_q;
    z_n_d      = z_n_q;
    w_n_d      = w_n_q;
    z_ng_d     = z_ng_q;
    w_ng_d     = w_ng_q;
    z_nc_d     = z_nc_q;
    w_nc_d     = w_nc_q;
    idx_d      = idx_q;
    out_n_d    = out_n_q;
    out_ng_d   = out_ng_q;
    out_nc_d   = out_nc_q;
    err_code_d = err_code_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (start_i) begin
          z_n_d   = z_n_i;   w_n_d  = w_n_i;
          z_ng_d  = z_ng_i;  w_ng_d = w_ng_i;
          z_nc_d  = z_nc_i;  w_nc_d = w_nc_i;
          state_d = S_CHECK;
        end
        S_CHECK: begin
          out_ng_d = ng_sum;
          out_nc_d = nc_sum;
          out_n_d  = z_n_q;
          idx_d    = '0;
          // Error priority: n mismatch, then ng overflow, then nc overflow.
          if (z_n_q != w_n_q) begin
            state_d = S_ERR; err_code_d = 2'b01; out_n_d = '0;
          end else if (ng_sum > NG_LIM) begin
            state_d = S_ERR; err_code_d = 2'b10; out_n_d = '0;
          end else if (nc_sum > NC_LIM) begin
            state_d = S_ERR; err_code_d = 2'b11; out_n_d = '0;
          end else if (z_n_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          idx_d = idx_q + 1'b1;
          if (NW'(idx_q) == z_n_q - NW'(1)) state_d = S_DRAIN;
        end
        S_DRAIN: if (pipe_empty) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      z_n_q      <= '0;  w_n_q  <= '0;
      z_ng_q     <= '0;  w_ng_q <= '0;
      z_nc_q     <= '0;  w_nc_q <= '0;
      idx_q      <= '0;
      out_n_q    <= '0;
      out_ng_q   <= '0;
      out_nc_q   <= '0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      z_n_q      <= z_n_d;   w_n_q  <= w_n_d;
      z_ng_q     <= z_ng_d;  w_ng_q <= w_ng_d;
      z_nc_q     <= z_nc_d;  w_nc_q <= w_nc_d;
      idx_q      <= idx_d;
      out_n_q    <= out_n_d;
      out_ng_q   <= out_ng_d;
      out_nc_q   <= out_nc_d;
      err_code_q <= err_code_d;
    end
  end

  assign rd_vld_o   = (state_q == S_ISSUE);
  assign rd_idx_o   = idx_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign err_o      = (state_q == S_ERR);
  assign err_code_o = err_o ? err_code_q : 2'b00;
  assign out_n_o    = out_n_q;
  assign out_ng_o   = out_ng_q;
  assign out_nc_o   = out_nc_q;
  assign wr_data_o  = sum_i;

  // Write pipe mirrors the adder latency so wr_addr lines up with sum_i.
  if (ADD_LAT > 0) begin : g_pipe
    logic [ADD_LAT-1:0]         vld_pipe_q;
    logic [ADD_LAT-1:0][IW-1:0] idx_pipe_q;
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        vld_pipe_q <= '0;
        idx_pipe_q <= '0;
      end else begin
        vld_pipe_q[0] <= rd_vld_o & ~abort_i;
        idx_pipe_q[0] <= rd_idx_o;
        for (int s = 1; s < ADD_LAT; s++) begin
          vld_pipe_q[s] <= vld_pipe_q[s-1] & ~abort_i;
          idx_pipe_q[s] <= idx_pipe_q[s-1];
        end
      end
    end
    assign wr_en_o    = vld_pipe_q[ADD_LAT-1];
    assign wr_addr_o  = idx_pipe_q[ADD_LAT-1];
    assign pipe_empty = ~|vld_pipe_q;
  end else begin : g_nopipe
    assign wr_en_o    = rd_vld_o;
    assign wr_addr_o  = rd_idx_o;
    assign pipe_empty = 1'b1;
  end

endmodule

// File: tb/tb_czono_plus_ctrl.sv
// Bench for czono_plus_ctrl: three instances at adder latency 0/1/3 share stimulus,
// each compared against a cycle-level expectation derived from dims and latency.
module tb_czono_plus_ctrl;
  localparam int NMAX = 16, NGMAX = 8, NCMAX = 8, K = 3, BUDGET = 30;
  localparam int LATS [K] = '{0, 1, 3};

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0;
  logic [4:0] z_n, w_n;
  logic [3:0] z_ng, w_ng, z_nc, w_nc;
  logic [31:0] zc [NMAX], wc [NMAX];

  logic        rd_vld_a [K], wr_en_a [K], busy_a [K], done_a [K], err_a [K];
  logic [3:0]  rd_idx_a [K], wr_addr_a [K];
  logic [31:0] wr_data_a [K];
  logic [4:0]  out_n_a [K], out_ng_a [K], out_nc_a [K];
  logic [1:0]  err_code_a [K];

  int n_vec = 0, n_mis = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < K; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    logic [31:0] s0, sum;
    assign s0 = zc[rd_idx_a[g]] + wc[rd_idx_a[g]];
    if (L == 0) begin : g_comb
      assign sum = s0;
    end else begin : g_lat
      logic [31:0] dl [L];
      always @(posedge clk) begin
        dl[0] <= s0;
        for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
      end
      assign sum = dl[L-1];
    end
    czono_plus_ctrl #(.NMAX(NMAX), .NGMAX(NGMAX), .NCMAX(NCMAX), .DATA_WIDTH(32), .ADD_LAT(L)) u_dut (
      .clk_i(clk), .rstn_i(rstn), .start_i(start), .abort_i(abort),
      .z_n_i(z_n), .w_n_i(w_n), .z_ng_i(z_ng), .w_ng_i(w_ng), .z_nc_i(z_nc), .w_nc_i(w_nc),
      .rd_vld_o(rd_vld_a[g]), .rd_idx_o(rd_idx_a[g]), .sum_i(sum),
      .wr_en_o(wr_en_a[g]), .wr_addr_o(wr_addr_a[g]), .wr_data_o(wr_data_a[g]),
      .out_n_o(out_n_a[g]), .out_ng_o(out_ng_a[g]), .out_nc_o(out_nc_a[g]),
      .busy_o(busy_a[g]), .done_o(done_a[g]), .err_o(err_a[g]), .err_code_o(err_code_a[g]));
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(string tag);
    for (int k = 0; k < K; k++) begin
      chk($sformatf("%s L%0d ctl", tag, LATS[k]),
          {26'd0, busy_a[k], rd_vld_a[k], wr_en_a[k], done_a[k], err_a[k], |err_code_a[k]}, 32'd0);
      chk($sformatf("%s L%0d dims", tag, LATS[k]),
          {17'd0, out_n_a[k], out_ng_a[k], out_nc_a[k]}, 32'd0);
    end
  endtask

  function automatic int exp_code(int zn, int wn, int zng, int wng, int znc, int wnc);
    if (zn != wn) return 1;
    if (zng + wng > NGMAX) return 2;
    if (znc + wnc > NCMAX) return 3;
    return 0;
  endfunction

  task automatic run_op(string nm, int zn, int wn, int zng, int wng, int znc, int wnc,
                        int abort_at = -1, int hold_until = 0);
    int wr_cyc [K][$], wr_adr [K][$];
    logic [31:0] wr_dat [K][$];
    int done_cnt [K], done_cyc [K], err_cnt [K], err_cyc [K], err_cd [K];
    int bad_code [K], rd_cnt [K], rd_bad [K];
    int code, nexp, exp_rd, L;
    for (int i = 0; i < NMAX; i++) begin zc[i] = $urandom; wc[i] = $urandom; end
    for (int k = 0; k < K; k++) begin
      done_cnt[k] = 0; done_cyc[k] = -1; err_cnt[k] = 0; err_cyc[k] = -1; err_cd[k] = 0;
      bad_code[k] = 0; rd_cnt[k] = 0; rd_bad[k] = 0;
    end
    @(posedge clk); #1;
    z_n = 5'(zn); w_n = 5'(wn); z_ng = 4'(zng); w_ng = 4'(wng); z_nc = 4'(znc); w_nc = 4'(wnc);
    start = 1'b1; abort = (abort_at == 0);
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < K; k++) begin
        if (wr_en_a[k]) begin
          wr_cyc[k].push_back(cyc); wr_adr[k].push_back(int'(wr_addr_a[k]));
          wr_dat[k].push_back(wr_data_a[k]);
        end
        if (done_a[k]) begin done_cnt[k]++; done_cyc[k] = cyc; end
        if (err_a[k]) begin err_cnt[k]++; err_cyc[k] = cyc; err_cd[k] = int'(err_code_a[k]); end
        else if (err_code_a[k] != 2'b00) bad_code[k]++;
        if (rd_vld_a[k]) begin
          rd_cnt[k]++;
          if (int'(rd_idx_a[k]) != cyc - 2) rd_bad[k]++;
        end
      end
      @(posedge clk); #1;
      start = (cyc + 1 <= hold_until);
      abort = (cyc + 1 == abort_at);
      // Dims wander while busy; only the values at start may matter.
      z_n = 5'($urandom); w_n = 5'($urandom); z_ng = 4'($urandom);
      w_ng = 4'($urandom); z_nc = 4'($urandom); w_nc = 4'($urandom);
    end
    code = exp_code(zn, wn, zng, wng, znc, wnc);
    for (int k = 0; k < K; k++) begin
      L = LATS[k];
      nexp = 0;
      if (code == 0)
        for (int j = 0; j < zn; j++) if (abort_at < 0 || 2 + j + L <= abort_at) nexp++;
      exp_rd = (code != 0) ? 0 : (abort_at < 0) ? zn : ((zn < abort_at - 1) ? zn : abort_at - 1);
      chk($sformatf("%s L%0d err_cnt", nm, L), err_cnt[k], (code != 0) ? 1 : 0);
      if (code != 0) begin
        chk($sformatf("%s L%0d err_cyc", nm, L), err_cyc[k], 2);
        chk($sformatf("%s L%0d err_code", nm, L), err_cd[k], code);
      end
      chk($sformatf("%s L%0d idle_code", nm, L), bad_code[k], 0);
      chk($sformatf("%s L%0d rd_cnt", nm, L), rd_cnt[k], exp_rd);
      chk($sformatf("%s L%0d rd_order", nm, L), rd_bad[k], 0);
      chk($sformatf("%s L%0d wr_cnt", nm, L), wr_adr[k].size(), nexp);
      for (int j = 0; j < nexp && j < wr_adr[k].size(); j++) begin
        chk($sformatf("%s L%0d wr%0d addr", nm, L, j), wr_adr[k][j], j);
        chk($sformatf("%s L%0d wr%0d data", nm, L, j), wr_dat[k][j], zc[j] + wc[j]);
        chk($sformatf("%s L%0d wr%0d cyc", nm, L, j), wr_cyc[k][j], 2 + j + L);
      end
      chk($sformatf("%s L%0d done_cnt", nm, L), done_cnt[k], (code == 0 && abort_at < 0) ? 1 : 0);
      if (code == 0 && abort_at < 0)
        chk($sformatf("%s L%0d done_cyc", nm, L), done_cyc[k], (zn == 0) ? 2 : zn + L + 3);
      chk($sformatf("%s L%0d out_n", nm, L), out_n_a[k], (code != 0) ? 0 : zn);
      chk($sformatf("%s L%0d out_ng", nm, L), out_ng_a[k], zng + wng);
      chk($sformatf("%s L%0d out_nc", nm, L), out_nc_a[k], znc + wnc);
      chk($sformatf("%s L%0d busy_end", nm, L), busy_a[k], 0);
    end
  endtask

  initial begin
    int zn, wn, pulses;
    z_n = '0; w_n = '0; z_ng = '0; w_ng = '0; z_nc = '0; w_nc = '0;
    for (int i = 0; i < NMAX; i++) begin zc[i] = '0; wc[i] = '0; end
    #2 chk_zero("reset");
    @(negedge clk); rstn = 1'b1;

    run_op("T1", 4, 4, 3, 2, 1, 2);
    run_op("T2", 4, 3, 1, 1, 1, 1);
    run_op("T3ng", 6, 6, 5, 4, 1, 1);
    run_op("T3nc", 6, 6, 2, 2, 5, 4);
    run_op("T3both", 6, 6, 5, 4, 5, 4);
    run_op("T4zero", 0, 0, 2, 3, 0, 0);
    run_op("T4max", NMAX, NMAX, 8, 0, 0, 8);
    run_op("T5abort", 8, 8, 1, 1, 1, 1, 4);
    run_op("T5hold", 4, 4, 2, 2, 2, 2, -1, 5);

    for (int r = 0; r < 8; r++) begin
      zn = $urandom_range(0, NMAX);
      wn = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NMAX) : zn;
      run_op($sformatf("R%0d", r), zn, wn, $urandom_range(0, 8), $urandom_range(0, 8),
             $urandom_range(0, 8), $urandom_range(0, 8));
    end

    // Async reset while the latency-3 instance is in DRAIN.
    @(posedge clk); #1;
    z_n = 5'd4; w_n = 5'd4; z_ng = 4'd1; w_ng = 4'd1; z_nc = 4'd1; w_nc = 4'd1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rstn = 1'b0;
    #1 chk_zero("T6rst");
    @(negedge clk); rstn = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      for (int k = 0; k < K; k++) pulses += int'(done_a[k]) + int'(err_a[k]) + int'(wr_en_a[k]);
    end
    chk("T6 post-reset pulses", pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
